inv_add_round_key_stage: RTL

Sequential AddRoundKey stage of the AES-128 decryption datapath. It sits directly downstream of the inverse S-box ROM stage and consumes its 128-bit state output. It holds the 11 expanded round keys in a local key file and steps a round counter from 10 down to 0. For each accepted state beat it XORs in the round key for the current round and presents the result, tagged with the round index, to the inverse MixColumns / round-loop logic.

---
 rtl/inv_add_round_key_stage.sv | 90 +++++++++
 1 files changed

// File: rtl/inv_add_round_key_stage.sv
// AES-128 decryption AddRoundKey stage: local round-key file plus a round
// counter stepping 10 -> 0; each accepted state beat is XORed with key[round].
module inv_add_round_key_stage #(
  parameter int TEXT_WIDTH = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_W    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  key_we_i,
  input  logic [ROUND_W-1:0]    key_addr_i,
  input  logic [TEXT_WIDTH-1:0] key_data_i,
  input  logic                  start_i,
  input  logic                  valid_i,
  input  logic [TEXT_WIDTH-1:0] cyphertext_temp_i,
  output logic [TEXT_WIDTH-1:0] cyphertext_temp_o,
  output logic                  valid_o,
  output logic [ROUND_W-1:0]    round_o,
  output logic                  last_round_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [ROUND_W-1:0]    round;
  logic [TEXT_WIDTH-1:0] key_file [0:NUM_ROUNDS];

  // Keys are frozen while a block is in flight so every round sees one key set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) key_file[i] <= '0;
    end else if (key_we_i && (key_addr_i <= LAST_ROUND) && (state != RUN)) begin
      key_file[key_addr_i] <= key_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      round             <= LAST_ROUND;
      cyphertext_temp_o <= '0;
      valid_o           <= 1'b0;
      round_o           <= '0;
      last_round_o      <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      valid_o      <= 1'b0;
      last_round_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            round  <= LAST_ROUND;
            state  <= RUN;
            busy_o <= 1'b1;
          end
        end
        RUN: begin
          if (valid_i) begin
            cyphertext_temp_o <= cyphertext_temp_i ^ key_file[round];
            round_o           <= round;
            valid_o           <= 1'b1;
            last_round_o      <= (round == '0);
            if (round == '0) begin
              state  <= DONE;
              busy_o <= 1'b0;
            end else begin
              round <= round - 1'b1;
            end
          end
        end
        DONE: begin
          done_o <= 1'b1;
          round  <= LAST_ROUND;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
